// File: rtl/bitcounter_down_4.sv
// bitcounter_down_4 -- loadable down-counter with IDLE/RUN/DONE control.
//
// A load with a non-zero value starts a countdown (busy=1). Each enabled
// cycle in RUN decrements the count; when it would go from 1 to 0 the
// counter enters DONE for exactly one cycle, with tc=1 and count=0, and
// then returns to IDLE. A load of zero goes straight to DONE. Load has
// priority over en, and the synchronous reset has priority over everything.
//
// Optional feature: define BITCOUNTER_DOWN_4_AUTO_RELOAD_EN to make the
// counter reload the last non-zero load value instead of finishing. The
// tc pulse then coincides with the reload, and the counter stays in RUN.
// With this option, DONE is reached only by loading zero.

module bitcounter_down_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1'b1);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_busy;
    logic             r_tc;

`ifdef BITCOUNTER_DOWN_4_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;

    // Remember the last non-zero start value so the countdown can restart itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reload <= C_ZERO;
        end else if (load && (load_val != C_ZERO)) begin
            r_reload <= load_val;
        end else begin
            r_reload <= r_reload;
        end
    end
`endif

    // Control FSM: state, count and the registered busy/tc flags advance together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= C_ZERO;
            r_busy  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (load) begin
            if (load_val != C_ZERO) begin
                r_state <= ST_RUN;
                r_count <= load_val;
                r_busy  <= 1'b1;
                r_tc    <= 1'b0;
            end else begin
                r_state <= ST_DONE;
                r_count <= C_ZERO;
                r_busy  <= 1'b0;
                r_tc    <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                    r_count <= C_ZERO;
                    r_busy  <= 1'b0;
                    r_tc    <= 1'b0;
                end
                ST_RUN: begin
                    if (!en) begin
                        r_state <= ST_RUN;
                        r_count <= r_count;
                        r_busy  <= 1'b1;
                        r_tc    <= 1'b0;
                    end else if (r_count > C_ONE) begin
                        r_state <= ST_RUN;
                        r_count <= r_count - C_ONE;
                        r_busy  <= 1'b1;
                        r_tc    <= 1'b0;
                    end else begin
                        // Count is 1 (0 cannot occur in RUN): terminal edge.
`ifdef BITCOUNTER_DOWN_4_AUTO_RELOAD_EN
                        r_state <= ST_RUN;
                        r_count <= r_reload;
                        r_busy  <= 1'b1;
                        r_tc    <= 1'b1;
`else
                        r_state <= ST_DONE;
                        r_count <= C_ZERO;
                        r_busy  <= 1'b0;
                        r_tc    <= 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_count <= C_ZERO;
                    r_busy  <= 1'b0;
                    r_tc    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= C_ZERO;
                    r_busy  <= 1'b0;
                    r_tc    <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign tc    = r_tc;

endmodule

// File: doc/bitcounter_down_4.md
BITCOUNTER_DOWN_4 -- requirements
Module: bitcounter_down_4

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL provide port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL provide port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port load  input  1  load request; captures load_val and starts a countdown.
REQ-005 SHALL provide port load_val  input  WIDTH  start value for the countdown.
REQ-006 SHALL provide port en  input  1  count enable; when high in RUN, the count decrements once per cycle.
REQ-007 SHALL provide port count  output  WIDTH  current count, registered.
REQ-008 SHALL provide port busy  output  1  high while in RUN, registered.
REQ-009 SHALL provide port tc  output  1  terminal-count pulse, registered, one cycle wide.

Function
REQ-010 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-011 SHALL, in any state with load=1 and load_val!=0, set count<=load_val, set reload_reg<=load_val, and enter RUN on the next edge.
REQ-012 SHALL, in any state with load=1 and load_val==0, set count<=0 and enter DONE on the next edge.
REQ-013 SHALL give load priority over en; load during RUN restarts the countdown with no tc.
REQ-014 SHALL, in RUN with en=1 and count>1, decrement count by exactly 1 per cycle.
REQ-015 SHALL, in RUN with en=1 and count==1, set count<=0 and enter DONE; tc is asserted in the same cycle that count first reads 0.
REQ-016 SHALL, in RUN with en=0, hold count and state.
REQ-017 SHALL assert tc for exactly the single cycle spent in DONE, then return unconditionally to IDLE (unless load=1, per REQ-011/012).
REQ-018 SHALL hold count at 0 in IDLE; the count never wraps below 0 and never increments.
REQ-019 SHALL drive busy=1 only in RUN and tc=1 only in DONE, both directly from registered state.
REQ-020 SHALL ignore en in IDLE and DONE.

Reset
REQ-021 SHALL, when reset=1 at a rising clk edge, set count=0, reload_reg=0, state=IDLE, busy=0, tc=0.
REQ-022 SHALL give reset priority over load and en, including mid-countdown and in DONE; no tc is produced by a reset.
REQ-023 SHALL leave outputs undefined only before the first clk edge with reset=1.

Configuration
REQ-024 SHALL use the macro BITCOUNTER_DOWN_4_AUTO_RELOAD_EN to select reload behaviour.
REQ-025 SHALL, with the macro defined, in RUN with en=1 and count==1, set count<=reload_reg, pulse tc for one cycle, and remain in RUN (busy stays 1); DONE is reached only via load with load_val==0.
REQ-026 SHALL, with the macro undefined, behave per REQ-015/017 with no reload; reload_reg may be omitted.

Verification
REQ-027 SHALL cover basic countdown: reset, then load=1 with load_val=3 for 1 cycle, then en=1 -> count 3,2,1,0; tc=1 only in the cycle count=0; busy 1→0 at that edge; IDLE next.
REQ-028 SHALL cover en gaps: load 5, then en toggled 1,0,1,1,0,1,1 -> count 5,4,4,3,2,2,1,0; exactly one tc pulse.
REQ-029 SHALL cover zero load and priority: load_val=0 -> tc=1 for one cycle with busy=0; load=1 (val 9) together with en=1 in RUN at count=2 -> count=9 next cycle, no tc.
REQ-030 SHALL cover reset mid-operation: load 15, count down to 7, assert reset with load=1 and en=1 -> count=0, busy=0, tc=0 next cycle; the countdown does not resume.
REQ-031 SHALL cover auto-reload: with the macro defined, load 2 and hold en=1 -> count 2,1,2,1,2...; tc pulses every 2 cycles on the reload edge; busy stays 1.
REQ-032 SHALL cover the WIDTH boundary: load_val=4'hF -> 15 decrements to 0 with no wrap; count stays 0 in IDLE with en=1 held.
